// File: rtl/slice_add_pkg.sv
// slice_add_pkg: shared state encoding and slice width for the sequential slice adder
package slice_add_pkg;
    localparam int SLICE_W = 4;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/r4_adder.sv
// r4_adder: 4-bit ripple-carry adder built from full-adder cells
module r4_adder (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);
    logic [4:0] c;
    assign c[0] = cin;
    for (genvar i = 0; i < 4; i++) begin : g_fa
        assign sum[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    assign cout = c[4];
endmodule

// File: rtl/slice_add_seq.sv
// slice_add_seq: WIDTH-bit adder that reuses one 4-bit slice over WIDTH/4 cycles, LSB slice first
module slice_add_seq
    import slice_add_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);
    localparam int N  = WIDTH / SLICE_W;
    localparam int IW = $clog2(N);

    state_t             state;
    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_reg;
    logic [IW-1:0]      idx;
    logic               carry;
    logic [SLICE_W-1:0] a_sl;
    logic [SLICE_W-1:0] b_sl;
    logic [SLICE_W-1:0] s_sl;
    logic               c_sl;

    assign a_sl      = a_reg[SLICE_W * int'(idx) +: SLICE_W];
    assign b_sl      = b_reg[SLICE_W * int'(idx) +: SLICE_W];
    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;
    assign busy      = state != IDLE;

    r4_adder u_add (
        .a    (a_sl),
        .b    (b_sl),
        .cin  (carry),
        .sum  (s_sl),
        .cout (c_sl)
    );

    // capture operands, step one slice per RUN cycle, hold the result in DONE until taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            a_reg <= '0;
            b_reg <= '0;
            idx   <= '0;
            carry <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    a_reg <= a;
                    b_reg <= b;
                    carry <= cin;
                    idx   <= '0;
                    state <= RUN;
                end
                RUN: begin
                    sum[SLICE_W * int'(idx) +: SLICE_W] <= s_sl;
                    carry <= c_sl;
                    if (idx == IW'(N - 1)) begin
                        cout  <= c_sl;
                        state <= DONE;
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                DONE: if (out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_slice_add_seq.sv
// tb_slice_add_seq: self-checking bench with a cycle-level reference model plus directed literal vectors
module tb_slice_add_seq;
    localparam int W = 16;
    localparam int N = W / 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] sum;
    logic         cout;
    logic         busy;

    int tests = 0;
    int fails = 0;
    bit rnd = 1'b0;

    logic         m_busy;
    int           m_left;
    logic [W:0]   m_pend;
    logic [W:0]   m_val;

    slice_add_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    // reference: a handshake starts an N-cycle countdown, then the full-width sum is presented until taken
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0;
            m_left <= 0;
            m_pend <= '0;
            m_val  <= '0;
        end else if (!m_busy) begin
            if (in_valid) begin
                m_busy <= 1'b1;
                m_left <= N;
                m_pend <= {1'b0, a} + {1'b0, b} + (W + 1)'(cin);
            end
        end else if (m_left != 0) begin
            m_left <= m_left - 1;
            if (m_left == 1) m_val <= m_pend;
        end else if (out_ready) begin
            m_busy <= 1'b0;
        end
    end

    // compare DUT against the reference every cycle, away from the rising edge
    always @(negedge clk) begin
        if (rst_n) begin
            chk("in_ready", 32'(in_ready), 32'(!m_busy));
            chk("busy", 32'(busy), 32'(m_busy));
            chk("out_valid", 32'(out_valid), 32'(m_busy && m_left == 0));
            if (!(m_busy && m_left != 0)) chk("result", 32'({cout, sum}), 32'(m_val));
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
        if (rnd) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic do_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ic);
        int n;
        n = 0;
        in_valid = 1'b1;
        a = ia;
        b = ib;
        cin = ic;
        while (!in_ready && n < 50) begin
            tick;
            n++;
        end
        if (!in_ready) chk("in_ready_timeout", 32'(in_ready), 32'd1);
        tick;
        in_valid = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        cin = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_result(input string nm, input logic [W-1:0] es, input logic ec);
        int lat;
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick;
            lat++;
        end
        chk({nm, "_latency"}, 32'(lat), 32'(N));
        chk({nm, "_sum"}, 32'(sum), 32'(es));
        chk({nm, "_cout"}, 32'(cout), 32'(ec));
    endtask

    initial begin
        repeat (3) tick;
        rst_n = 1'b1;
        tick;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);

        do_op(16'hFFFF, 16'h0001, 1'b0); wait_result("ffff_p1", 16'h0000, 1'b1); tick;
        do_op(16'h000F, 16'h0001, 1'b0); wait_result("c0", 16'h0010, 1'b0); tick;
        do_op(16'h00FF, 16'h0001, 1'b0); wait_result("c1", 16'h0100, 1'b0); tick;
        do_op(16'h0FFF, 16'h0001, 1'b0); wait_result("c2", 16'h1000, 1'b0); tick;
        do_op(16'hFFFF, 16'h0000, 1'b1); wait_result("cin_only", 16'h0000, 1'b1); tick;
        do_op(16'h1234, 16'h4321, 1'b0); wait_result("no_carry", 16'h5555, 1'b0); tick;
        chk("retain_sum", 32'(sum), 32'h5555);

        out_ready = 1'b0;
        do_op(16'h8001, 16'h8002, 1'b1);
        wait_result("bp", 16'h0004, 1'b1);
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            a = W'($urandom);
            b = W'($urandom);
            tick;
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_hold", 32'({cout, sum}), 32'h10004);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick;
        chk("bp_release", 32'(out_valid), 32'd0);

        do_op(16'hAAAA, 16'h5555, 1'b1);
        tick;
        tick;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_sum", 32'(sum), 32'd0);
        chk("mid_rst_cout", 32'(cout), 32'd0);
        tick;
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick;
            chk("post_rst_no_valid", 32'(out_valid), 32'd0);
        end
        do_op(16'h0001, 16'h0001, 1'b0); wait_result("after_rst", 16'h0002, 1'b0); tick;

        rnd = 1'b1;
        for (int k = 0; k < 1000; k++) begin
            repeat ($urandom_range(0, 3)) tick;
            do_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
        end
        rnd = 1'b0;
        out_ready = 1'b1;
        repeat (N + 4) tick;
        chk("drain_idle", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
